// File: rtl/mult_result_acc.sv
// mult_result_acc: aligns the multiplier-tree issue strobe with its pipeline
// latency, then accumulates COUNT results into a batch sum and maximum that is
// presented on a valid/ready port. The batch that completes while the previous
// one is still unaccepted is dropped, and the sticky overrun flag is set.
module mult_result_acc #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned COUNT = 8,
  parameter int unsigned DW    = 8,
  localparam int unsigned SW   = DW + $clog2(COUNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_result,
  input  logic          i_clr,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [SW-1:0] o_sum,
  output logic [DW-1:0] o_max,
  output logic          o_overrun
);

  localparam int unsigned CW = $clog2(COUNT);
  localparam logic [CW-1:0] LAST_CNT = CW'(COUNT - 1);

  logic [LAT-1:0] vline_q, vline_d;
  logic [SW-1:0]  acc_q, acc_d;
  logic [DW-1:0]  max_q, max_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic [SW-1:0]  sum_q, sum_d;
  logic [DW-1:0]  omax_q, omax_d;
  logic           ovr_q, ovr_d;

  logic           av_c;
  logic           last_c;
  logic           load_c;
  logic [SW-1:0]  acc_nx_c;
  logic [DW-1:0]  max_nx_c;

  // Aligned strobe and the running sum/max including the current result
  always_comb begin
    av_c     = vline_q[LAT-1];
    last_c   = av_c && (cnt_q == LAST_CNT);
    load_c   = last_c && (!valid_q || i_ready);
    acc_nx_c = acc_q + SW'(i_result);
    max_nx_c = (i_result > max_q) ? i_result : max_q;
  end

  // Next-state: batch accumulation, output load/accept/drop, clear priority
  always_comb begin
    vline_d = (vline_q << 1) | LAT'(i_valid);
    acc_d   = acc_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    omax_d  = omax_q;
    ovr_d   = ovr_q;

    if (av_c) begin
      if (last_c) begin
        acc_d = '0;
        max_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_nx_c;
        max_d = max_nx_c;
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (load_c) begin
      valid_d = 1'b1;
      sum_d   = acc_nx_c;
      omax_d  = max_nx_c;
    end else if (last_c) begin
      // Output still held by the consumer: discard the new batch
      ovr_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    if (i_clr) begin
      vline_d = '0;
      acc_d   = '0;
      max_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      sum_d   = '0;
      omax_d  = '0;
      ovr_d   = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vline_q <= '0;
      acc_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      omax_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      vline_q <= vline_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      omax_q  <= omax_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_sum     = sum_q;
  assign o_max     = omax_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_mult_result_acc.sv
// Testbench for mult_result_acc: directed scenarios plus random traffic,
// checked by a scoreboard fed from a batch-level reference model.
module tb_mult_result_acc;

  localparam int LAT   = 2;
  localparam int COUNT = 8;
  localparam int DW    = 8;
  localparam int SW    = DW + $clog2(COUNT);

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic [DW-1:0] i_result;
  logic          i_clr;
  logic          o_valid;
  logic          i_ready;
  logic [SW-1:0] o_sum;
  logic [DW-1:0] o_max;
  logic          o_overrun;

  mult_result_acc #(.LAT(LAT), .COUNT(COUNT), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_result  (i_result),
    .i_clr     (i_clr),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_sum     (o_sum),
    .o_max     (o_max),
    .o_overrun (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; int val; } fl_t;
  typedef struct { int sum; int mx; } exp_t;

  fl_t  inflight[$];
  exp_t sbq[$];
  int   batch[$];
  bit   exp_valid;
  bit   exp_ov;
  bit   exp_zero;
  int   cyc;
  int   rdy_mode;
  int   n_cmp;
  int   n_fail;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    batch.delete();
    sbq.delete();
    exp_valid = 1'b0;
    exp_ov    = 1'b0;
    exp_zero  = 1'b1;
  endtask

  // Batch-level reference: collect COUNT aligned results, then sum/max them
  task automatic model_edge(input bit ar, input int val, input bit rdy, input bit clr);
    bit   done;
    exp_t e;
    if (clr) begin
      model_clear();
      return;
    end
    done = 1'b0;
    if (ar) begin
      batch.push_back(val);
      if (batch.size() == COUNT) done = 1'b1;
    end
    if (done) begin
      e.sum = 0;
      e.mx  = 0;
      foreach (batch[k]) begin
        e.sum += batch[k];
        if (batch[k] > e.mx) e.mx = batch[k];
      end
      if (!exp_valid || rdy) begin
        sbq.push_back(e);
        exp_valid = 1'b1;
        exp_zero  = 1'b0;
      end else begin
        exp_ov = 1'b1;
      end
      batch.delete();
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
  endtask

  // One clock: drive inputs for the coming edge, then apply it to the model
  task automatic cycle(input bit v, input int val, input bit clr);
    bit ar;
    int aval;
    bit rdy;
    ar   = 1'b0;
    aval = 0;
    if (inflight.size() > 0 && inflight[0].due == cyc) begin
      ar   = 1'b1;
      aval = inflight[0].val;
      void'(inflight.pop_front());
    end
    case (rdy_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      2:       rdy = 1'($urandom_range(0, 1));
      default: rdy = ar && (batch.size() == COUNT - 1);
    endcase
    i_valid  = v;
    i_result = ar ? DW'(aval) : DW'($urandom);
    i_ready  = rdy;
    i_clr    = clr;
    if (clr) inflight.delete();
    else if (v) inflight.push_back('{cyc + LAT, val & 255});
    @(posedge clk);
    model_edge(ar, aval, rdy, clr);
    cyc++;
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    inflight.delete();
    model_clear();
    i_valid  = 1'b1;
    i_result = 8'hFF;
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #2;
    rst_n   = 1'b1;
    i_valid = 1'b0;
  endtask

  // Monitor: compares flags every cycle and pops the scoreboard on handshake
  always @(negedge clk) begin
    chk("o_valid", longint'(o_valid), longint'(exp_valid));
    chk("o_overrun", longint'(o_overrun), longint'(exp_ov));
    if (exp_zero) begin
      chk("o_sum_reset", longint'(o_sum), 0);
      chk("o_max_reset", longint'(o_max), 0);
    end
    if (o_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL scoreboard: o_valid high with no expected batch (t=%0t)", $time);
      end else begin
        chk("o_sum", longint'(o_sum), longint'(sbq[0].sum));
        chk("o_max", longint'(o_max), longint'(sbq[0].mx));
        if (i_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    int gv[8];
    gv = '{10, 200, 5, 255, 0, 7, 255, 1};
    n_cmp = 0; n_fail = 0; cyc = 0; rdy_mode = 0;
    rst_n = 1'b0; i_valid = 1'b0; i_result = '0; i_clr = 1'b0; i_ready = 1'b0;
    model_clear();

    // Reset with busy-looking inputs, then idle
    @(posedge clk);
    #2;
    do_reset(3);
    idle(4);

    // Basic batch of 3s
    repeat (COUNT) cycle(1'b1, 3, 1'b0);
    idle(LAT + 2);
    chk("basic_sum", longint'(o_sum), 24);
    chk("basic_max", longint'(o_max), 3);
    rdy_mode = 1; idle(2); rdy_mode = 0;

    // Full-scale values with 2-cycle gaps
    foreach (gv[k]) begin
      cycle(1'b1, gv[k], 1'b0);
      idle(2);
    end
    idle(LAT + 2);
    chk("fullscale_sum", longint'(o_sum), 733);
    chk("fullscale_max", longint'(o_max), 255);
    rdy_mode = 1; idle(2); rdy_mode = 0;

    // Overrun under backpressure
    repeat (2 * COUNT) cycle(1'b1, 1, 1'b0);
    idle(LAT + 2);
    chk("overrun_sum", longint'(o_sum), 8);
    chk("overrun_flag", longint'(o_overrun), 1);
    rdy_mode = 1; idle(2); rdy_mode = 0;
    chk("overrun_sticky", longint'(o_overrun), 1);
    cycle(1'b0, 0, 1'b1);

    // Accept on the exact edge the next batch completes
    repeat (COUNT) cycle(1'b1, 2, 1'b0);
    idle(LAT + 2);
    rdy_mode = 3;
    repeat (COUNT) cycle(1'b1, 2, 1'b0);
    idle(LAT + 2);
    chk("simul_valid", longint'(o_valid), 1);
    chk("simul_sum", longint'(o_sum), 16);
    chk("simul_ovr", longint'(o_overrun), 0);
    rdy_mode = 1; idle(2); rdy_mode = 0;

    // Clear with results in flight
    repeat (7) cycle(1'b1, 9, 1'b0);
    cycle(1'b0, 0, 1'b1);
    repeat (COUNT) cycle(1'b1, 4, 1'b0);
    idle(LAT + 2);
    chk("clr_sum", longint'(o_sum), 32);
    rdy_mode = 1; idle(2); rdy_mode = 0;

    // Reset mid-batch, then mid-hold
    repeat (5) cycle(1'b1, 9, 1'b0);
    do_reset(2);
    repeat (COUNT) cycle(1'b1, 4, 1'b0);
    idle(LAT + 2);
    chk("rst_batch_sum", longint'(o_sum), 32);
    chk("rst_batch_ovr", longint'(o_overrun), 0);
    do_reset(1);
    repeat (COUNT) cycle(1'b1, 4, 1'b0);
    idle(LAT + 2);
    chk("rst_hold_sum", longint'(o_sum), 32);
    chk("rst_hold_ovr", longint'(o_overrun), 0);
    rdy_mode = 1; idle(2);

    // Random traffic
    for (int blk = 0; blk < 12; blk++) begin
      rdy_mode = int'($urandom_range(0, 3));
      for (int i = 0; i < 60; i++)
        cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
              1'($urandom_range(0, 80) == 0));
    end

    rdy_mode = 1;
    idle(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
